regfile_write_sequencer: RTL and testbench
==========================================

# regfile_write_sequencer

Owns the single write port of the 32×32 register file. After reset it sequences an initialisation pass over every register: registers 0–7 get their own index, all others get 0. It then shares the write port between two writeback requesters using round-robin arbitration. It sits between the ALU and load writeback paths and the register file's `regWrite`/`writeReg`/`writeData` inputs.

## Interface
Parameters:
- `NUM_REGS`, 32: registers initialised; equals 2^`ADDR_W`.
- `ADDR_W`, 5: register index width.
- `DATA_W`, 32: data width.
- `INIT_PRESET`, 8: registers 0..`INIT_PRESET`-1 initialise to their own index; the rest initialise to 0.

Ports:
- `clock_in` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `init_req` in 1: one-cycle request to rerun the initialisation pass.
- `req0_valid` in 1: requester 0 (ALU) has a write pending.
- `req0_reg` in `ADDR_W`: destination register for requester 0.
- `req0_data` in `DATA_W`: write data for requester 0.
- `req0_ready` out 1: requester 0 transfer accepted this cycle.
- `req1_valid`, `req1_reg`, `req1_data`, `req1_ready`: same as requester 0, for requester 1 (load).
- `regWrite` out 1: register file write enable, registered.
- `writeReg` out `ADDR_W`: register file write index, registered.
- `writeData` out `DATA_W`: register file write data, registered.
- `busy` out 1: high while in INIT.

## Operation
States:
- INIT (reset state):
  - A counter `cnt` runs from 0 to `NUM_REGS`-1, one write per cycle.
  - Each cycle issues `writeReg`=`cnt` and `writeData` = (`cnt` < `INIT_PRESET`) ? `cnt` : 0, with `regWrite`=1. `writeData` is zero-extended to `DATA_W`.
  - After the write with `cnt`=`NUM_REGS`-1, move to RUN.
- RUN:
  - The arbiter grants at most one requester per cycle.
  - `readyN` = RUN && grant==N. Ready is combinational from the valids and the priority pointer `prio`.
  - Only requester N valid: grant N.
  - Both valid: grant `prio`.
  - After any transfer from N, `prio` becomes the other requester.
  - A transfer is `valid` && `ready` at the rising edge. The winner's `reg`/`data` are registered onto the write port with `regWrite`=1.
  - A cycle with no transfer drives `regWrite`=0.
  - A write to register 0 is accepted (ready=1) but issued with `regWrite`=0; register 0 is never overwritten in RUN.
  - `init_req`=1 in RUN: no grant that cycle; next state is INIT with `cnt`=0.
  - `init_req` is ignored while in INIT.

Handshake rules:
- A requester holds `valid`, `reg`, and `data` stable until it sees `ready`.
- `ready` is never asserted in INIT.

Other rules:
- Both requesters target the same register: writes are serialised in grant order, so the last writer wins.
- Reset mid-operation: abort immediately. Pending requests are not acknowledged; the INIT pass restarts from `cnt`=0.

## Timing
- Reset values: `regWrite`=0, `writeReg`=0, `writeData`=0, `req0_ready`=0, `req1_ready`=0, `busy`=1, `prio`=0, `cnt`=0, state=INIT.
- First init write appears on the first rising edge after reset deasserts. INIT lasts exactly `NUM_REGS` cycles.
- `busy` drops in the cycle after the last init write has been registered.
- Handshake-to-write latency: 1 cycle. The write port is registered at the rising edge, so it is stable before the register file's negedge write in the same cycle.
- Throughput: one write per cycle in RUN.
- `init_req` → first INIT write: 2 cycles.

## Structure
- Shared package: `NUM_REGS`, `ADDR_W`, `DATA_W`, `INIT_PRESET`, and the state encoding (INIT=0, RUN=1).
- One sub-module, `rr_arbiter2`:
  - Inputs: two valids, `prio`.
  - Outputs: one-hot grant.
  - Purely combinational.
  - The pointer register lives in the parent.

## Test plan
- Reset, then idle:
  - 32 consecutive `regWrite` pulses with `writeReg` 0..31.
  - `writeData` = 0..7 for registers 0–7, then 0.
  - `busy` falls after register 31.
  - No ready asserted during INIT.
- RUN, `req0` alone, reg 9, data 0xDEADBEEF:
  - `req0_ready` high the same cycle.
  - Next cycle: `regWrite`=1, `writeReg`=9, `writeData`=0xDEADBEEF.
- Both valid and held for 4 cycles, `prio`=0:
  - Grants alternate 0,1,0,1.
  - Four back-to-back writes in that order.
- `req1` writes reg 0, data 5:
  - `req1_ready`=1.
  - Following cycle `regWrite`=0.
- `init_req` pulsed while `req0` is valid:
  - No ready that cycle.
  - Full 32-cycle INIT pass.
  - `req0` granted in the first RUN cycle with its held data.
- `reset` asserted mid-INIT (`cnt`=12) and mid-RUN with `req1` valid:
  - Outputs return to reset values asynchronously.
  - INIT restarts at `writeReg`=0.

Source files
------------

// File: rtl/regfile_write_sequencer_pkg.sv
// Shared sizing constants and FSM encoding for the register-file write sequencer.
package regfile_write_sequencer_pkg;

    localparam int NUM_REGS    = 32;
    localparam int ADDR_W      = 5;
    localparam int DATA_W      = 32;
    localparam int INIT_PRESET = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_write_sequencer_rr_arbiter2.sv
// Two-way round-robin grant logic; the priority pointer is owned by the caller.
module rr_arbiter2
    import regfile_write_sequencer_pkg::*;
(
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_prio,
    output logic [1:0] o_grant
);

    // On contention the pointer decides; otherwise the lone requester wins.
    assign o_grant[0] = i_valid0 && (!i_valid1 || !i_prio);
    assign o_grant[1] = i_valid1 && (!i_valid0 ||  i_prio);

endmodule

// File: rtl/regfile_write_sequencer.sv
// Owns the register-file write port: an initialisation sweep after reset or init_req,
// then round-robin sharing between the ALU and load writeback requesters.
module regfile_write_sequencer
    import regfile_write_sequencer_pkg::*;
#(
    parameter int NUM_REGS_P    = NUM_REGS,
    parameter int ADDR_W_P      = ADDR_W,
    parameter int DATA_W_P      = DATA_W,
    parameter int INIT_PRESET_P = INIT_PRESET
) (
    input  logic                clock_in,
    input  logic                reset,
    input  logic                init_req,
    input  logic                req0_valid,
    input  logic [ADDR_W_P-1:0] req0_reg,
    input  logic [DATA_W_P-1:0] req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [ADDR_W_P-1:0] req1_reg,
    input  logic [DATA_W_P-1:0] req1_data,
    output logic                req1_ready,
    output logic                regWrite,
    output logic [ADDR_W_P-1:0] writeReg,
    output logic [DATA_W_P-1:0] writeData,
    output logic                busy
);

    localparam logic [ADDR_W_P-1:0] LAST_IDX   = ADDR_W_P'(NUM_REGS_P - 1);
    localparam logic [ADDR_W_P:0]   PRESET_CMP = (ADDR_W_P + 1)'(INIT_PRESET_P);

    state_t                r_state;
    logic [ADDR_W_P-1:0]   r_cnt;
    logic                  r_prio;
    logic                  r_regwrite;
    logic [ADDR_W_P-1:0]   r_writereg;
    logic [DATA_W_P-1:0]   r_writedata;

    state_t                w_state_next;
    logic [ADDR_W_P-1:0]   w_cnt_next;
    logic                  w_prio_next;
    logic                  w_regwrite_next;
    logic [ADDR_W_P-1:0]   w_writereg_next;
    logic [DATA_W_P-1:0]   w_writedata_next;
    logic [1:0]            w_grant;
    logic [1:0]            w_ready;
    logic [ADDR_W_P-1:0]   w_sel_reg;
    logic [DATA_W_P-1:0]   w_sel_data;

    rr_arbiter2 u_arb (
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .i_prio   (r_prio),
        .o_grant  (w_grant)
    );

    assign w_sel_reg  = w_grant[1] ? req1_reg  : req0_reg;
    assign w_sel_data = w_grant[1] ? req1_data : req0_data;

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_prio_next      = r_prio;
        w_regwrite_next  = 1'b0;
        w_writereg_next  = r_writereg;
        w_writedata_next = r_writedata;
        w_ready          = 2'b00;
        case (r_state)
            ST_INIT: begin
                w_regwrite_next  = 1'b1;
                w_writereg_next  = r_cnt;
                w_writedata_next = ({1'b0, r_cnt} < PRESET_CMP) ? DATA_W_P'(r_cnt) : '0;
                w_cnt_next       = r_cnt + 1'b1;
                if (r_cnt == LAST_IDX) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = '0;
                end
            end
            ST_RUN: begin
                if (init_req) begin
                    w_state_next = ST_INIT;
                    w_cnt_next   = '0;
                end else begin
                    w_ready = w_grant;
                    if (w_grant != 2'b00) begin
                        // Register 0 is hard-wired: accept the transfer but suppress the write.
                        w_regwrite_next  = (w_sel_reg != '0);
                        w_writereg_next  = w_sel_reg;
                        w_writedata_next = w_sel_data;
                        w_prio_next      = w_grant[0];
                    end
                end
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_prio      <= 1'b0;
            r_regwrite  <= 1'b0;
            r_writereg  <= '0;
            r_writedata <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_prio      <= w_prio_next;
            r_regwrite  <= w_regwrite_next;
            r_writereg  <= w_writereg_next;
            r_writedata <= w_writedata_next;
        end
    end

    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];
    assign regWrite   = r_regwrite;
    assign writeReg   = r_writereg;
    assign writeData  = r_writedata;
    assign busy       = (r_state == ST_INIT);

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Bench for regfile_write_sequencer: directed vector table, init/reset sequences,
// and randomized requester traffic against a spec-level model with a shadow register file.
module tb_regfile_write_sequencer;

    logic        clk;
    logic        reset;
    logic        init_req;
    logic        req0_valid;
    logic [4:0]  req0_reg;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_reg;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic [31:0] rf_dut   [32];
    logic [31:0] mem_model[32];
    logic        m_prio;

    typedef struct {
        logic        v0;
        logic [4:0]  r0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_rw;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[10];

    regfile_write_sequencer dut (
        .clock_in   (clk),
        .reset      (reset),
        .init_req   (init_req),
        .req0_valid (req0_valid),
        .req0_reg   (req0_reg),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_reg   (req1_reg),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .regWrite   (regWrite),
        .writeReg   (writeReg),
        .writeData  (writeData),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shadow register file: captures the port on the negedge, like the real file.
    always @(negedge clk) begin
        if (regWrite) rf_dut[writeReg] <= writeData;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] r1, input logic [31:0] d1);
        req0_valid = v0; req0_reg = r0; req0_data = d0;
        req1_valid = v1; req1_reg = r1; req1_data = d1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " regWrite"},  {31'd0, regWrite},   32'd0);
        chk({tag, " writeReg"},  {27'd0, writeReg},   32'd0);
        chk({tag, " writeData"}, writeData,           32'd0);
        chk({tag, " busy"},      {31'd0, busy},       32'd1);
        chk({tag, " ready"},     {30'd0, req1_ready, req0_ready}, 32'd0);
    endtask

    // Runs n init cycles from cnt=0; entered between edges, leaves at posedge+1.
    task automatic init_pass(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            #1;
            chk({tag, " init no-ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
            @(posedge clk); #1;
            chk({tag, " init regWrite"}, {31'd0, regWrite}, 32'd1);
            chk({tag, " init writeReg"}, {27'd0, writeReg}, k);
            chk({tag, " init writeData"}, writeData, (k < 8) ? k : 0);
            chk({tag, " init busy"}, {31'd0, busy}, (k == 31) ? 32'd0 : 32'd1);
            $display("[TB] %s init write reg=%0d data=0x%0h busy=%0b", tag, writeReg, writeData, busy);
        end
        if (n == 32) begin
            for (int i = 0; i < 32; i++) mem_model[i] = (i < 8) ? i : 0;
        end
    endtask

    function automatic logic [1:0] model_grant(input logic v0, input logic v1, input logic prio);
        if (v0 && v1) return prio ? 2'b10 : 2'b01;
        return {v1, v0};
    endfunction

    initial begin
        logic        p0, p1;
        logic [4:0]  rr0, rr1;
        logic [31:0] dd0, dd1;
        logic [1:0]  g;
        logic        exp_rw;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;

        vecs[0] = '{1'b1, 5'd9,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,     1'b1, 1'b0, 1'b1, 5'd9,  32'hDEADBEEF};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h33,    1'b0, 1'b1, 1'b1, 5'd3,  32'h33};
        vecs[2] = '{1'b1, 5'd10, 32'hA0A0,     1'b1, 5'd11, 32'hB1B1,  1'b1, 1'b0, 1'b1, 5'd10, 32'hA0A0};
        vecs[3] = '{1'b1, 5'd10, 32'hA0A0,     1'b1, 5'd11, 32'hB1B1,  1'b0, 1'b1, 1'b1, 5'd11, 32'hB1B1};
        vecs[4] = '{1'b1, 5'd10, 32'hA0A0,     1'b1, 5'd11, 32'hB1B1,  1'b1, 1'b0, 1'b1, 5'd10, 32'hA0A0};
        vecs[5] = '{1'b1, 5'd10, 32'hA0A0,     1'b1, 5'd11, 32'hB1B1,  1'b0, 1'b1, 1'b1, 5'd11, 32'hB1B1};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h5,     1'b0, 1'b1, 1'b0, 5'd0,  32'h0};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[8] = '{1'b1, 5'd20, 32'h100,      1'b1, 5'd20, 32'h200,   1'b1, 1'b0, 1'b1, 5'd20, 32'h100};
        vecs[9] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd20, 32'h200,   1'b0, 1'b1, 1'b1, 5'd20, 32'h200};

        for (int i = 0; i < 32; i++) begin
            rf_dut[i]    = 32'h0;
            mem_model[i] = 32'h0;
        end

        // Reset values, with both requesters pushing so ready suppression is visible.
        reset = 1'b0; init_req = 1'b0;
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66);
        #2 reset = 1'b1;
        #1 chk_reset_outputs("por");
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        init_pass(32, "por");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Directed vectors in RUN; prio starts at 0.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].v0, vecs[i].r0, vecs[i].d0, vecs[i].v1, vecs[i].r1, vecs[i].d1);
            @(negedge clk);
            chk($sformatf("vec%0d ready0", i), {31'd0, req0_ready}, {31'd0, vecs[i].e_rdy0});
            chk($sformatf("vec%0d ready1", i), {31'd0, req1_ready}, {31'd0, vecs[i].e_rdy1});
            @(posedge clk); #1;
            chk($sformatf("vec%0d regWrite", i), {31'd0, regWrite}, {31'd0, vecs[i].e_rw});
            if (vecs[i].e_rw) begin
                chk($sformatf("vec%0d writeReg", i), {27'd0, writeReg}, {27'd0, vecs[i].e_reg});
                chk($sformatf("vec%0d writeData", i), writeData, vecs[i].e_data);
                mem_model[vecs[i].e_reg] = vecs[i].e_data;
            end
            $display("[TB] vec%0d rdy=%0b%0b rw=%0b reg=%0d data=0x%0h",
                     i, vecs[i].e_rdy1, vecs[i].e_rdy0, regWrite, writeReg, writeData);
        end

        // Randomized traffic; the table above finishes with requester 1 granted, so prio is 0.
        m_prio = 1'b0;
        p0 = 1'b0; p1 = 1'b0; rr0 = '0; rr1 = '0; dd0 = '0; dd1 = '0;
        for (int c = 0; c < 300; c++) begin
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0 = 1'b1; rr0 = 5'($urandom_range(0, 31)); dd0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 3) != 0) begin
                p1 = 1'b1; rr1 = 5'($urandom_range(0, 31)); dd1 = $urandom;
            end
            drive(p0, rr0, dd0, p1, rr1, dd1);
            @(negedge clk);
            g = model_grant(p0, p1, m_prio);
            chk("rand ready0", {31'd0, req0_ready}, {31'd0, g[0]});
            chk("rand ready1", {31'd0, req1_ready}, {31'd0, g[1]});
            exp_rw = 1'b0; exp_reg = '0; exp_data = '0;
            if (g != 2'b00) begin
                exp_reg  = g[1] ? rr1 : rr0;
                exp_data = g[1] ? dd1 : dd0;
                exp_rw   = (exp_reg != 5'd0);
                if (exp_rw) mem_model[exp_reg] = exp_data;
                m_prio = g[0];
                if (g[0]) p0 = 1'b0; else p1 = 1'b0;
            end
            @(posedge clk); #1;
            chk("rand regWrite", {31'd0, regWrite}, {31'd0, exp_rw});
            if (exp_rw) begin
                chk("rand writeReg", {27'd0, writeReg}, {27'd0, exp_reg});
                chk("rand writeData", writeData, exp_data);
                $display("[TB] rand cycle %0d grant=%0b reg=%0d data=0x%0h", c, g, writeReg, writeData);
            end
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk); #1;
        for (int i = 0; i < 32; i++) chk($sformatf("regfile[%0d]", i), rf_dut[i], mem_model[i]);
        $display("[TB] regfile contents compared against model");

        // init_req with req0 waiting: no grant, full sweep, then req0 goes first.
        @(posedge clk); #1;
        drive(1'b1, 5'd7, 32'hCAFE0007, 1'b0, 5'd0, 32'h0);
        init_req = 1'b1;
        @(negedge clk);
        chk("init_req ready0", {31'd0, req0_ready}, 32'd0);
        @(posedge clk); #1;
        init_req = 1'b0;
        chk("init_req gap regWrite", {31'd0, regWrite}, 32'd0);
        chk("init_req busy", {31'd0, busy}, 32'd1);
        init_pass(32, "reinit");
        @(negedge clk);
        chk("post-init ready0", {31'd0, req0_ready}, 32'd1);
        @(posedge clk); #1;
        chk("post-init writeReg", {27'd0, writeReg}, 32'd7);
        chk("post-init writeData", writeData, 32'hCAFE0007);
        chk("post-init regWrite", {31'd0, regWrite}, 32'd1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Reset during the sweep at cnt=12.
        #2 reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h22);
        init_pass(12, "partial");
        #2 reset = 1'b1;
        #1 chk_reset_outputs("mid-init rst");
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        init_pass(32, "after mid-init rst");

        // Reset in RUN while req1 is being acknowledged.
        drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0);
        @(posedge clk); #1;
        chk("pre-rst writeReg", {27'd0, writeReg}, 32'd9);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h55);
        #1 chk("pre-rst ready1", {31'd0, req1_ready}, 32'd1);
        #1 reset = 1'b1;
        #1 chk_reset_outputs("mid-run rst");
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        init_pass(32, "after mid-run rst");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
